// File: rtl/bounce_pkg.sv
// ============================================================================
//  Module      : bounce_pkg
//  Description : Shared types and constants for the bounce generator:
//                FSM state encoding, LFSR feedback taps and default seed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bounce_pkg;

  // Sequencer states; IDLE is the only non-busy state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Fibonacci feedback taps 16,14,13,11 expressed as a bit mask (bit 15 = tap 16).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // Default LFSR reset value; any nonzero value gives a full-length sequence.
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/bounce_generator_lfsr16.sv
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR, shifts every cycle and
//                loads the seed while reset is held low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next state: shift left, feedback is the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // State register; seed is a static value tied off by the parent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/bounce_generator.sv
// ============================================================================
//  Module      : bounce_generator
//  Description : Emulates a bouncing push-button contact. Each change of the
//                clean cmd level produces 2*BOUNCES+1 btn edges separated by
//                pseudo-random gaps, then a stable settle period and a
//                one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounce_generator
  import bounce_pkg::*;
#(
  parameter int          BOUNCES    = 4,
  parameter int          MAX_GAP    = 8,
  parameter int          SETTLE_CYC = 16,
  parameter logic [15:0] SEED       = DEFAULT_SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd,
  output logic btn,
  output logic busy,
  output logic done
);

  localparam int           GAP_IDX_W   = $clog2(MAX_GAP);
  localparam int           GAP_W       = GAP_IDX_W + 1;
  localparam logic [4:0]   REMAIN_LOAD = 5'(2 * BOUNCES);
  localparam logic [7:0]   SETTLE_LOAD = 8'(SETTLE_CYC);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  // --------------------------------------------------------------------------
  // Reset synchronizer: assertion is immediate, release waits two clk edges.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_int;

  // Shift ones into the synchronizer chain once reset is released.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchronizer flops, cleared asynchronously by the external reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Random source for the bounce gaps
  // --------------------------------------------------------------------------
  logic [15:0]      lfsr;
  logic [GAP_W-1:0] gap_seed;
  logic             unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (rst_n_int),
    .seed  (SEED),
    .q     (lfsr)
  );

  // Gap reload value: low LFSR bits plus one gives 1..MAX_GAP.
  assign gap_seed         = {1'b0, lfsr[GAP_IDX_W-1:0]} + GAP_ONE;
  assign unused_lfsr_bits = ^lfsr[15:GAP_IDX_W];

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic             btn_q,       btn_d;
  logic             target_q,    target_d;
  logic [4:0]       remaining_q, remaining_d;
  logic [GAP_W-1:0] gap_q,       gap_d;
  logic [7:0]       count_q,     count_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // Next-state and output logic for the IDLE/BOUNCE/SETTLE sequence.
  always_comb begin
    state_d     = state_q;
    btn_d       = btn_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    count_d     = count_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // A mismatch starts a sequence; the first edge happens right away.
        if (cmd != btn_q) begin
          btn_d    = cmd;
          target_d = cmd;
          if (BOUNCES == 0) begin
            state_d = SETTLE;
            count_d = SETTLE_LOAD;
          end else begin
            state_d     = BOUNCE;
            remaining_d = REMAIN_LOAD;
            gap_d       = gap_seed;
          end
        end
      end

      BOUNCE: begin
        if (gap_q == GAP_ONE) begin
          btn_d       = ~btn_q;
          remaining_d = remaining_q - 5'd1;
          // Even number of extra toggles, so the last one lands on target.
          if (remaining_q == 5'd1) begin
            state_d = SETTLE;
            count_d = SETTLE_LOAD;
            gap_d   = '0;
          end else begin
            gap_d = gap_seed;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end

      SETTLE: begin
        if (count_q == 8'd1) begin
          state_d = IDLE;
          count_d = 8'd0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Sequencer registers, held in reset until the synchronized release.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      btn_q       <= 1'b0;
      target_q    <= 1'b0;
      remaining_q <= 5'd0;
      gap_q       <= '0;
      count_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign btn  = btn_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bounce_generator.sv
// ============================================================================
//  Module      : tb_bounce_generator
//  Description : Self-checking bench for bounce_generator. Two instances:
//                defaults, and BOUNCES=0/SETTLE_CYC=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bounce_generator;

  localparam int MAXG = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic cmd   = 1'b0;
  logic cmd0  = 1'b0;
  logic btn, busy, done;
  logic btn0, busy0, done0;

  int total = 0;
  int bad   = 0;
  int r1;
  int r2;
  logic level;

  always #5 clk = ~clk;

  bounce_generator dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd),
    .btn   (btn),
    .busy  (busy),
    .done  (done)
  );

  bounce_generator #(.BOUNCES(0), .SETTLE_CYC(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd0),
    .btn   (btn0),
    .busy  (busy0),
    .done  (done0)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Watches one sequence until its done pulse and compares it with the
  // behaviour a bouncing contact must show: edge count, gap range, settle
  // length, final level and busy coverage.
  task automatic observe(input string tag, input bit which, input logic tgt,
                         input int n_bounce, input int settle_cyc, input bit chk_first);
    logic prev;
    logic b;
    logic y;
    logic d;
    int cyc = 0;
    int edges = 0;
    int last = 0;
    int first = 0;
    int mx = 0;
    int done_n = 0;
    int settle = 0;
    bit busy_ok = 1'b1;
    int budget;
    budget = 2 * n_bounce * MAXG + settle_cyc + 16;
    prev = which ? btn0 : btn;
    b = prev;
    while (done_n == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      b = which ? btn0 : btn;
      y = which ? busy0 : busy;
      d = which ? done0 : done;
      if (b !== prev) begin
        edges++;
        if (edges == 1) first = cyc;
        else if (cyc - last > mx) mx = cyc - last;
        last = cyc;
        prev = b;
      end
      if (d === 1'b1) begin
        done_n++;
        settle = cyc - last;
      end else if (edges > 0 && y !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    check({tag, ".done"}, done_n, 1);
    check({tag, ".edges"}, edges, 2 * n_bounce + 1);
    check({tag, ".final_btn"}, int'(b), int'(tgt));
    check({tag, ".settle"}, settle, settle_cyc);
    check({tag, ".busy"}, int'(busy_ok), 1);
    if (n_bounce > 0) check({tag, ".gap_range"}, int'(mx >= 1 && mx <= MAXG), 1);
    if (chk_first) check({tag, ".first_edge"}, first, 1);
  endtask

  // Confirms the instance stays idle, quiet and at the given level.
  task automatic quiet(input string tag, input bit which, input logic lvl, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if ((which ? busy0 : busy) !== 1'b0 || (which ? done0 : done) !== 1'b0 ||
          (which ? btn0 : btn) !== lvl) ok = 1'b0;
    end
    check({tag, ".quiet"}, int'(ok), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst.btn",   int'(btn),   0);
    check("rst.busy",  int'(busy),  0);
    check("rst.done",  int'(done),  0);
    check("rst.btn0",  int'(btn0),  0);
    check("rst.busy0", int'(busy0), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // No-bounce instance: single edge, done four cycles later
    cmd0 = 1'b1;
    observe("nb_rise", 1'b1, 1'b1, 0, 4, 1'b1);
    quiet("nb_rise", 1'b1, 1'b1, 3);
    cmd0 = 1'b0;
    observe("nb_fall", 1'b1, 1'b0, 0, 4, 1'b1);
    quiet("nb_fall", 1'b1, 1'b0, 3);

    // Default instance: rising and falling sequences
    repeat ($urandom_range(0, 4)) @(negedge clk);
    cmd = 1'b1;
    observe("rise", 1'b0, 1'b1, 4, 16, 1'b1);
    quiet("rise", 1'b0, 1'b1, 2);
    cmd = 1'b0;
    observe("fall", 1'b0, 1'b0, 4, 16, 1'b1);
    quiet("fall", 1'b0, 1'b0, 2);

    // cmd wiggles while busy and returns to the target: nothing new starts
    r1 = int'($urandom_range(2, 8));
    r2 = int'($urandom_range(1, 8));
    cmd = 1'b1;
    fork
      observe("ignore", 1'b0, 1'b1, 4, 16, 1'b1);
      begin
        repeat (r1) @(negedge clk);
        cmd = 1'b0;
        repeat (r2) @(negedge clk);
        cmd = 1'b1;
      end
    join
    quiet("ignore", 1'b0, 1'b1, 20);

    cmd = 1'b0;
    observe("fall2", 1'b0, 1'b0, 4, 16, 1'b1);
    quiet("fall2", 1'b0, 1'b0, 2);

    // cmd reverses mid-sequence and stays: second sequence right after done
    r1 = int'($urandom_range(2, 15));
    cmd = 1'b1;
    fork
      observe("pend1", 1'b0, 1'b1, 4, 16, 1'b1);
      begin
        repeat (r1) @(negedge clk);
        cmd = 1'b0;
      end
    join
    observe("pend2", 1'b0, 1'b0, 4, 16, 1'b1);
    quiet("pend2", 1'b0, 1'b0, 3);

    // Randomized idle spacing between clean level changes
    level = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      level = ~level;
      cmd = level;
      observe("rand", 1'b0, level, 4, 16, 1'b1);
    end
    quiet("rand", 1'b0, level, 2);

    // Reset in the middle of BOUNCE aborts immediately
    cmd = 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    check("abort.busy_before", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("abort.btn",  int'(btn),  0);
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    quiet("abort.held", 1'b0, 1'b0, 3);
    reset = 1'b1;
    observe("recover", 1'b0, 1'b1, 4, 16, 1'b0);
    quiet("recover", 1'b0, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
